// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, FSM type, S-box/Rcon tables and round helper functions
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam logic [3:0]  AES_NR      = 4'd10;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_t;

  // Forward S-box; element 0 is the leftmost entry
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants indexed by round number 1..10; padded so any 4-bit index is in range
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Byte i of the state sits at bits [127-8i -: 8]; row = i%4, column = i/4
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - combinational AES encryption round (last round skips MixColumns)
module aes_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   last_round,
  output logic [AES_BLOCK_W-1:0] next_state
);

  logic [AES_BLOCK_W-1:0] sub_bytes;
  logic [AES_BLOCK_W-1:0] shifted;
  logic [AES_BLOCK_W-1:0] mixed;

  // SubBytes: one S-box lookup per state byte
  always_comb begin
    sub_bytes = '0;
    for (int i = 0; i < 16; i++) begin
      sub_bytes[8*i +: 8] = SBOX[state[8*i +: 8]];
    end
  end

  assign shifted    = shift_rows(sub_bytes);
  assign mixed      = mix_columns(shifted);
  assign next_state = (last_round ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_128_encrypt.sv
// rtl/aes_128_encrypt.sv - iterative AES-128 encryptor, one round per clock; AES_DEBUG_PORTS_EN drives debug outputs
module aes_128_encrypt
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AES_BLOCK_W-1:0] plaintext,
  input  logic [AES_BLOCK_W-1:0] key,
  output logic [AES_BLOCK_W-1:0] ciphertext,
  output logic                   done,
  output logic [3:0]             round_count_out,
  output logic [AES_BLOCK_W-1:0] state_out
);

  aes_fsm_t               fsm;
  logic [AES_BLOCK_W-1:0] state_q;
  logic [AES_BLOCK_W-1:0] rkey_q;
  logic [AES_BLOCK_W-1:0] ct_q;
  logic [3:0]             round_q;
  logic                   done_q;

  logic [3:0]             round_next;
  logic [31:0]            w0, w1, w2, w3, t, n0, n1, n2, n3;
  logic [AES_BLOCK_W-1:0] rkey_next;
  logic [AES_BLOCK_W-1:0] round_out;

  assign round_next = round_q + 4'd1;

  // On-the-fly key expansion: derive the key for round round_next from the current one
  assign w0 = rkey_q[127:96];
  assign w1 = rkey_q[95:64];
  assign w2 = rkey_q[63:32];
  assign w3 = rkey_q[31:0];
  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {RCON[round_next], 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rkey_next = {n0, n1, n2, n3};

  aes_round u_round (
    .state      (state_q),
    .round_key  (rkey_next),
    .last_round (round_next == AES_NR),
    .next_state (round_out)
  );

  // Control FSM: capture inputs once, run ten rounds, then hold until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= LOAD;
      state_q <= '0;
      rkey_q  <= '0;
      ct_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (fsm)
        LOAD: begin
          state_q <= plaintext ^ key;
          rkey_q  <= key;
          round_q <= '0;
          fsm     <= ROUND;
        end
        ROUND: begin
          state_q <= round_out;
          rkey_q  <= rkey_next;
          round_q <= round_next;
          if (round_next == AES_NR) begin
            ct_q   <= round_out;
            done_q <= 1'b1;
            fsm    <= DONE;
          end
        end
        DONE: begin
          fsm <= DONE;
        end
        default: begin
          fsm <= LOAD;
        end
      endcase
    end
  end

  assign ciphertext = ct_q;
  assign done       = done_q;

`ifdef AES_DEBUG_PORTS_EN
  assign round_count_out = round_q;
  assign state_out       = state_q;
`else
  assign round_count_out = 4'd0;
  assign state_out       = '0;
`endif

endmodule

// File: tb/tb_aes_128_encrypt.sv
// tb/tb_aes_128_encrypt.sv - self-checking bench with a GF(2^8)-arithmetic AES reference model
module tb_aes_128_encrypt;

  logic         clk;
  logic         rst;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         done;
  logic [3:0]   round_count_out;
  logic [127:0] state_out;

  int errors = 0;
  int checks = 0;

  aes_128_encrypt dut (
    .clk             (clk),
    .rst             (rst),
    .plaintext       (plaintext),
    .key             (key),
    .ciphertext      (ciphertext),
    .done            (done),
    .round_count_out (round_count_out),
    .state_out       (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S-box derived from field inverse plus affine map, not copied from a table
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  // AES state after nr rounds (nr=0 is the initial AddRoundKey)
  function automatic logic [127:0] ref_state(input logic [127:0] pt, input logic [127:0] k, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int rr = 0; rr < 4; rr++) a[rr] = s[4*c+rr];
          for (int rr = 0; rr < 4; rr++)
            s[4*c+rr] = gmul(8'h02, a[rr]) ^ gmul(8'h03, a[(rr+1)%4]) ^ a[(rr+2)%4] ^ a[(rr+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Cycle-level expectation: -1 while waiting for the load edge, else rounds completed
  bit           armed = 1'b0;
  int           cnt = -1;
  logic [127:0] cap_pt, cap_key;

  // Track reset, load capture and round progress from the bench's own view of the inputs
  always @(posedge clk) begin
    if (rst) begin
      cnt   <= -1;
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == -1) begin
        cap_pt  <= plaintext;
        cap_key <= key;
        cnt     <= 0;
      end else if (cnt < 10) begin
        cnt <= cnt + 1;
      end
    end
  end

  logic [127:0] exp_ct, exp_st;
  logic [3:0]   exp_rc;
  logic         exp_done;

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      exp_done = (cnt == 10);
      exp_ct   = exp_done ? ref_state(cap_pt, cap_key, 10) : 128'h0;
`ifdef AES_DEBUG_PORTS_EN
      exp_rc   = (cnt < 0) ? 4'd0 : 4'(cnt);
      exp_st   = (cnt < 0) ? 128'h0 : ref_state(cap_pt, cap_key, cnt);
`else
      exp_rc   = 4'd0;
      exp_st   = 128'h0;
`endif
      check("mon_done", {127'h0, done}, {127'h0, exp_done});
      check("mon_ciphertext", ciphertext, exp_ct);
      check("mon_round_count", {124'h0, round_count_out}, {124'h0, exp_rc});
      check("mon_state_out", state_out, exp_st);
    end
  end

  // Reset, load, scramble inputs, then confirm done timing and the result
  task automatic run_vec(input string name, input logic [127:0] pt, input logic [127:0] k,
                         input logic [127:0] exp);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    plaintext = pt;
    key = k;
    tick();
    plaintext = rnd128();
    key = rnd128();
    for (int e = 2; e <= 11; e++) begin
      tick();
      check({name, "_done_edge"}, {127'h0, done}, {127'h0, (e == 11)});
    end
    check({name, "_ct"}, ciphertext, exp);
  endtask

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] E_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] E_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  initial begin
    logic [127:0] pt, k;
    rst = 1'b1;
    plaintext = '0;
    key = '0;
    build_sbox();

    check("model_appB", ref_state(B_PT, B_KEY, 10), B_CT);
    check("model_appC1", ref_state(C_PT, C_KEY, 10), C_CT);
    check("model_ecb", ref_state(E_PT, B_KEY, 10), E_CT);
    check("model_appB_r0", ref_state(B_PT, B_KEY, 0), 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    tick();
    tick();
    check("reset_ct", ciphertext, 128'h0);
    check("reset_done", {127'h0, done}, 128'h0);
    check("reset_state", state_out, 128'h0);
    check("reset_rc", {124'h0, round_count_out}, 128'h0);

    // App. B with debug-state pin after the load edge
    rst = 1'b0;
    plaintext = B_PT;
    key = B_KEY;
    tick();
`ifdef AES_DEBUG_PORTS_EN
    check("appB_state_load", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
`endif
    repeat (10) tick();
    check("appB_ct", ciphertext, B_CT);
    check("appB_done", {127'h0, done}, 128'h1);
`ifdef AES_DEBUG_PORTS_EN
    check("appB_rc", {124'h0, round_count_out}, 128'd10);
`endif

    run_vec("appC1", C_PT, C_KEY, C_CT);
    run_vec("ecb", E_PT, B_KEY, E_CT);
    repeat (20) tick();
    check("hold_ct", ciphertext, E_CT);
    check("hold_done", {127'h0, done}, 128'h1);

    // Abort at round 5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    plaintext = rnd128();
    key = rnd128();
    tick();
    repeat (5) tick();
`ifdef AES_DEBUG_PORTS_EN
    check("mid_rc_before", {124'h0, round_count_out}, 128'd5);
`endif
    rst = 1'b1;
    tick();
    check("mid_rc_after", {124'h0, round_count_out}, 128'h0);
    check("mid_done_after", {127'h0, done}, 128'h0);
    rst = 1'b0;
    plaintext = B_PT;
    key = B_KEY;
    tick();
    repeat (10) tick();
    check("mid_restart_ct", ciphertext, B_CT);

    for (int v = 0; v < 8; v++) begin
      pt = rnd128();
      k  = rnd128();
      run_vec("rand", pt, k, ref_state(pt, k, 10));
      repeat ($urandom_range(0, 5)) tick();
    end

    rst = 1'b1;
    tick();
    check("final_reset_ct", ciphertext, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_128_encrypt.md
Name: aes_128_encrypt

Overview:
- Iterative AES-128 encryption core (FIPS-197) performing one round per clock, with on-the-fly key expansion.
- A reset pulse starts each operation; plaintext and key are captured on the first clock after reset.
- Used as the cipher datapath in the crypto subsystem; debug outputs expose round progress.

Parameters:
- None. Block size 128, key size 128 and round count 10 are fixed constants in the package.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset; one clock, reset synchronous and active-high.
- plaintext  input  128  block to encrypt; bits [127:120] are byte 0 (FIPS byte order).
- key  input  128  cipher key, same byte order.
- ciphertext  output  128  result; valid while done=1.
- done  output  1  high when ciphertext is valid.
- round_count_out  output  4  rounds completed, 0..10.
- state_out  output  128  current AES state register.

Behaviour:
- Reset (rst=1 at a rising edge): FSM<=LOAD. ciphertext, state, round key, round_count_out and done all <=0. Reset has priority in every state, including mid-operation, and aborts the current operation.
- LOAD, first edge with rst=0:
  - state<=plaintext^key, round key<=key, round_count<=0, FSM<=ROUND.
  - Inputs are used only at this edge; later changes are ignored.
- ROUND, next 10 edges:
  - round key<=next expanded key, using RotWord, SubWord and Rcon[round].
  - For rounds 1..9: state<=AddRoundKey(MixColumns(ShiftRows(SubBytes(state)))).
  - Round 10 omits MixColumns.
  - round_count increments by 1 each edge.
  - On the round-10 edge: ciphertext<=result, done<=1, FSM<=DONE.
- Latency: done rises after the 11th rising edge following reset deassertion.
- DONE: all registers hold, with done=1 and round_count_out=10, until the next reset. There is no auto-restart.
- round_count_out never exceeds 10. Rcon is indexed 1..10 (01,02,04,08,10,20,40,80,1b,36).
- state_out equals the state register at all times; it equals ciphertext once done=1.
- The S-box is combinational (16 state lookups plus 4 key lookups per cycle). No multicycle paths.

Optional Feature:
- Macro AES_DEBUG_PORTS_EN.
- Defined: round_count_out and state_out are driven as described above.
- Undefined: both outputs are tied to 0. Ports remain present, and ciphertext, done and latency are unchanged.

Decomposition:
- Package aes_pkg holds:
  - constants: AES_BLOCK_W=128, AES_NR=10;
  - FSM enum type: LOAD, ROUND, DONE;
  - the 256-entry S-box table and the Rcon table;
  - functions: xtime, sub_word, shift_rows, mix_columns.
- One sub-module, aes_round: combinational round taking state, round key and a last-round flag, and producing the next state.
- Key expansion stays in the top level.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32; done rises exactly at edge 11; round_count_out=10.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- SP800-38A ECB: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 6bc1bee22e409f96e93d7e117393172a -> 3ad77bb40d7a3660a89ecaf32466ef97.
- Reset values and mid-operation reset:
  - During reset: all outputs are 0.
  - Assert rst at round 5 -> next edge round_count_out=0 and done=0.
  - Release rst -> the new vector completes correctly 11 edges later.
- Input stability: change plaintext and key after the LOAD edge -> ciphertext matches the values captured at LOAD; after done, outputs hold for 20 further cycles.
- Debug ports:
  - state_out after the LOAD edge of the App. B case equals 193de3bea0f4e22b9ac68d2ae9f84808.
  - round_count_out steps 0..10 on consecutive edges.
